// File: rtl/debounced_step_counter_pkg.sv
// Shared definitions for the debounced step counter.
// Holds the debounce FSM state encoding and the bit positions of the
// 8-bit io bus so the top and the debouncer agree on one map.
package debounced_step_counter_pkg;

  // The two stable states differ from their pending states in bit 0,
  // and bit 1 follows the debounced level.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b11,
    PEND_LO   = 2'b10
  } db_state_e;

  localparam int CLK_BIT   = 0;
  localparam int RST_BIT   = 1;
  localparam int STEP_BIT  = 2;
  localparam int DIR_BIT   = 3;
  localparam int LOAD_BIT  = 4;
  localparam int LDVAL_LSB = 5;
  localparam int LDVAL_W   = 3;

endpackage

// File: rtl/debounced_step_counter_btn_debouncer.sv
// Push-button debouncer: 2-flop synchronizer followed by a four-state
// debounce FSM with a run-length counter.
// Ports:
//   i_clk        rising-edge clock
//   i_rst        async active-high reset
//   i_btn        raw, asynchronous, bouncy button
//   o_db_level   debounced button level (registered)
//   o_rise_pulse high in the cycle whose closing edge enters STABLE_HI;
//                decoded from flops only, lets the parent act on that edge
//   o_busy       registered, high while a level change is pending
module debounced_step_counter_btn_debouncer
  import debounced_step_counter_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_db_level,
  output logic o_rise_pulse,
  output logic o_busy
);

  localparam int             DB_W    = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic             r_sync1;
  logic             r_btn_s;
  db_state_e        r_state;
  db_state_e        w_state_nxt;
  logic [DB_W-1:0]  r_db_cnt;
  logic [DB_W-1:0]  w_db_cnt_nxt;
  logic             r_db_level;
  logic             w_db_level_nxt;
  logic             w_rise;
  logic             r_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_btn_s <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= STABLE_LO;
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_db_cnt   <= w_db_cnt_nxt;
      r_db_level <= w_db_level_nxt;
      r_busy     <= (w_state_nxt == PEND_HI) || (w_state_nxt == PEND_LO);
    end
  end

  // The pending states count consecutive samples at the new level; the
  // first opposite sample throws the attempt away.
  always_comb begin
    w_state_nxt    = r_state;
    w_db_cnt_nxt   = r_db_cnt;
    w_db_level_nxt = r_db_level;
    w_rise         = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (r_btn_s) begin
          w_state_nxt  = PEND_HI;
          w_db_cnt_nxt = DB_ONE;
        end
      end
      PEND_HI: begin
        if (!r_btn_s) begin
          w_state_nxt  = STABLE_LO;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt    = STABLE_HI;
          w_db_cnt_nxt   = '0;
          w_db_level_nxt = 1'b1;
          w_rise         = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_ONE;
        end
      end
      STABLE_HI: begin
        if (!r_btn_s) begin
          w_state_nxt  = PEND_LO;
          w_db_cnt_nxt = DB_ONE;
        end
      end
      PEND_LO: begin
        if (r_btn_s) begin
          w_state_nxt  = STABLE_HI;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt    = STABLE_LO;
          w_db_cnt_nxt   = '0;
          w_db_level_nxt = 1'b0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_ONE;
        end
      end
      default: begin
        w_state_nxt  = STABLE_LO;
        w_db_cnt_nxt = '0;
      end
    endcase
  end

  assign o_db_level   = r_db_level;
  assign o_rise_pulse = w_rise;
  assign o_busy       = r_busy;

endmodule

// File: rtl/debounced_step_counter.sv
// Debounced up/down modulo step counter with parallel load.
// A debounced button press steps the counter once; the count feeds the
// 3-bit seven-segment decoder.
// Ports (8-bit io bus):
//   io_in[0] clk, io_in[1] rst (async, active-high), io_in[2] step_btn,
//   io_in[3] dir (1 = up), io_in[4] load, io_in[7:5] load_val
//   io_out[2:0] count, io_out[3] wrap, io_out[4] db_level,
//   io_out[5] step_pulse, io_out[6] busy, io_out[7] dir_s
module debounced_step_counter
  import debounced_step_counter_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3,
  parameter int MODULO    = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MODULO - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [LDVAL_W:0]   LD_LIMIT = (LDVAL_W + 1)'(MODULO);

  logic               w_clk;
  logic               w_rst;
  logic               r_dir_meta;
  logic               r_dir_s;
  logic               r_load_meta;
  logic               r_load_s;
  logic [LDVAL_W-1:0] r_ldval_meta;
  logic [LDVAL_W-1:0] r_ldval_s;
  logic               w_db_level;
  logic               w_rise;
  logic               w_busy;
  logic [CNT_W-1:0]   r_count;
  logic               r_wrap;
  logic               r_step_pulse;

  assign w_clk = io_in[CLK_BIT];
  assign w_rst = io_in[RST_BIT];

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_dir_meta   <= 1'b0;
      r_dir_s      <= 1'b0;
      r_load_meta  <= 1'b0;
      r_load_s     <= 1'b0;
      r_ldval_meta <= '0;
      r_ldval_s    <= '0;
    end else begin
      r_dir_meta   <= io_in[DIR_BIT];
      r_dir_s      <= r_dir_meta;
      r_load_meta  <= io_in[LOAD_BIT];
      r_load_s     <= r_load_meta;
      r_ldval_meta <= io_in[LDVAL_LSB +: LDVAL_W];
      r_ldval_s    <= r_ldval_meta;
    end
  end

  debounced_step_counter_btn_debouncer #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debouncer (
    .i_clk        (w_clk),
    .i_rst        (w_rst),
    .i_btn        (io_in[STEP_BIT]),
    .o_db_level   (w_db_level),
    .o_rise_pulse (w_rise),
    .o_busy       (w_busy)
  );

  // Load wins over a coincident step: the count takes the load value and
  // wrap stays low, but the step pulse is still reported.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_count      <= '0;
      r_wrap       <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= w_rise;
      r_wrap       <= 1'b0;
      if (r_load_s) begin
        r_count <= ({1'b0, r_ldval_s} >= LD_LIMIT) ? '0 : CNT_W'(r_ldval_s);
      end else if (w_rise) begin
        if (r_dir_s) begin
          if (r_count == CNT_MAX) begin
            r_count <= '0;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= r_count + CNT_ONE;
          end
        end else begin
          if (r_count == '0) begin
            r_count <= CNT_MAX;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= r_count - CNT_ONE;
          end
        end
      end
    end
  end

  assign io_out = {r_dir_s, w_busy, r_step_pulse, w_db_level, r_wrap, r_count};

endmodule
